// File: rtl/img_proc_pkg.sv
// Shared types and constants for the RGB888 -> luma/chroma front end of the median-filter chain.
// Holds BT.601 integer coefficients, pipeline latency, pixel type and frame-monitor state encoding.
package img_proc_pkg;

  localparam int PIPE_LAT = 3;

  typedef logic [7:0] pix8_t;

  localparam logic [15:0] Y_R   = 16'd77;
  localparam logic [15:0] Y_G   = 16'd150;
  localparam logic [15:0] Y_B   = 16'd29;
  localparam logic [15:0] Y_OFS = 16'd128;

  localparam logic signed [17:0] CB_R  = -18'sd43;
  localparam logic signed [17:0] CB_G  = -18'sd85;
  localparam logic signed [17:0] CB_B  = 18'sd128;
  localparam logic signed [17:0] CR_R  = 18'sd128;
  localparam logic signed [17:0] CR_G  = -18'sd107;
  localparam logic signed [17:0] CR_B  = -18'sd21;
  localparam logic signed [17:0] C_OFS = 18'sd32896;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_ACTIVE,
    MON_REPORT
  } mon_state_t;

  function automatic logic signed [17:0] to_s18(input pix8_t p);
    return signed'({10'd0, p});
  endfunction

  // Pure blue (Cb) and pure red (Cr) land exactly on 65536, one past the byte range.
  function automatic pix8_t clamp_u8(input logic signed [17:0] v);
    if (v < 0) return '0;
    if (v[16]) return 8'hFF;
    return v[15:8];
  endfunction

endpackage

// File: rtl/rgb888_to_gray_proc_if.sv
// Pixel-stream bundle between the RGB source, rgb888_to_gray_proc and med_filter_proc.
// Chroma signals exist only when RGB2GRAY_CBCR_EN is defined.
interface rgb888_to_gray_proc_if;
  import img_proc_pkg::*;

  logic  per_img_vsync;
  logic  per_img_href;
  pix8_t per_img_red;
  pix8_t per_img_green;
  pix8_t per_img_blue;

  logic  post_img_vsync;
  logic  post_img_href;
  pix8_t post_img_gray;
  logic  frame_done;
  logic  frame_err;

`ifdef RGB2GRAY_CBCR_EN
  pix8_t post_img_cb;
  pix8_t post_img_cr;

  modport master (
    output per_img_vsync, per_img_href, per_img_red, per_img_green, per_img_blue,
    input  post_img_vsync, post_img_href, post_img_gray, frame_done, frame_err,
    input  post_img_cb, post_img_cr
  );

  modport slave (
    input  per_img_vsync, per_img_href, per_img_red, per_img_green, per_img_blue,
    output post_img_vsync, post_img_href, post_img_gray, frame_done, frame_err,
    output post_img_cb, post_img_cr
  );
`else
  modport master (
    output per_img_vsync, per_img_href, per_img_red, per_img_green, per_img_blue,
    input  post_img_vsync, post_img_href, post_img_gray, frame_done, frame_err
  );

  modport slave (
    input  per_img_vsync, per_img_href, per_img_red, per_img_green, per_img_blue,
    output post_img_vsync, post_img_href, post_img_gray, frame_done, frame_err
  );
`endif

endinterface

// File: rtl/rgb2gray_frame_mon.sv
// Input-side frame geometry monitor: counts pixels per line and lines per frame between vsync edges,
// then reports one frame_done/frame_err pulse aligned with the delayed post_img_vsync fall.
module rgb2gray_frame_mon
  import img_proc_pkg::*;
#(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic frame_done,
  output logic frame_err
);

  localparam int H_W = $clog2(IMG_H_DISP) + 1;
  localparam int V_W = $clog2(IMG_V_DISP) + 1;

  mon_state_t          state;
  logic                vsync_q;
  logic                href_q;
  logic [H_W-1:0]      pix_cnt;
  logic [V_W-1:0]      line_cnt;
  logic                err_sticky;
  logic [PIPE_LAT-2:0] done_sr;
  logic [PIPE_LAT-2:0] err_sr;

  logic rise, fall, count_en, line_close, line_bad, report, report_err;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    rise       = 1'b0;
    fall       = 1'b0;
    count_en   = 1'b0;
    line_close = 1'b0;
    line_bad   = 1'b0;
    report     = 1'b0;
    report_err = 1'b0;

    rise       = vsync & ~vsync_q;
    fall       = ~vsync & vsync_q;
    count_en   = vsync & href & ((state == MON_ACTIVE) | ((state == MON_IDLE) & rise));
    // A line still open when vsync drops is closed on that same cycle.
    line_close = (state == MON_ACTIVE) & href_q & (~href | ~vsync);
    line_bad   = (pix_cnt != H_W'(IMG_H_DISP));
    report     = (state == MON_REPORT);
    report_err = report & (err_sticky | (line_cnt != V_W'(IMG_V_DISP)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MON_IDLE;
      // Treat vsync as already high so a frame in progress at reset release is never seen as a rise.
      vsync_q    <= 1'b1;
      href_q     <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      err_sticky <= 1'b0;
      done_sr    <= '0;
      err_sr     <= '0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      done_sr <= {done_sr[PIPE_LAT-3:0], report};
      err_sr  <= {err_sr[PIPE_LAT-3:0], report_err};

      if (count_en) begin
        if (!href_q)          pix_cnt <= H_W'(1);
        else if (!(&pix_cnt)) pix_cnt <= pix_cnt + 1'b1;
      end

      if (line_close) begin
        if (line_bad)      err_sticky <= 1'b1;
        if (!(&line_cnt))  line_cnt   <= line_cnt + 1'b1;
      end

      unique case (state)
        MON_IDLE:   if (rise) state <= MON_ACTIVE;
        MON_ACTIVE: if (fall) state <= MON_REPORT;
        MON_REPORT: begin
          state      <= MON_IDLE;
          pix_cnt    <= '0;
          line_cnt   <= '0;
          err_sticky <= 1'b0;
        end
        default:    state <= MON_IDLE;
      endcase
    end
  end

  assign frame_done = done_sr[PIPE_LAT-2];
  assign frame_err  = err_sr[PIPE_LAT-2];

endmodule

// File: rtl/rgb888_to_gray_proc.sv
// RGB888 vsync/href stream to 8-bit BT.601 luma with a fixed 3-cycle pipeline and matching sync delay.
// Optional chroma outputs post_img_cb/post_img_cr are built when RGB2GRAY_CBCR_EN is defined.
module rgb888_to_gray_proc
  import img_proc_pkg::*;
#(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480
) (
  input logic                  clk,
  input logic                  rst,
  rgb888_to_gray_proc_if.slave bus
);

  logic [15:0]         y_r_prod, y_g_prod, y_b_prod;
  logic [15:0]         y_sum;
  pix8_t               gray_q;
  logic [PIPE_LAT-1:0] vsync_sr;
  logic [PIPE_LAT-1:0] href_sr;
  logic                href_s2;

  // href aligned with the S2 sum register, used to gate the S3 result.
  assign href_s2 = href_sr[PIPE_LAT-2];

  // NOTE: registered state uses <= so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r_prod <= '0;
      y_g_prod <= '0;
      y_b_prod <= '0;
      y_sum    <= '0;
      gray_q   <= '0;
      vsync_sr <= '0;
      href_sr  <= '0;
    end else begin
      y_r_prod <= Y_R * {8'd0, bus.per_img_red};
      y_g_prod <= Y_G * {8'd0, bus.per_img_green};
      y_b_prod <= Y_B * {8'd0, bus.per_img_blue};
      y_sum    <= y_r_prod + y_g_prod + y_b_prod + Y_OFS;
      gray_q   <= href_s2 ? y_sum[15:8] : '0;
      vsync_sr <= {vsync_sr[PIPE_LAT-2:0], bus.per_img_vsync};
      href_sr  <= {href_sr[PIPE_LAT-2:0], bus.per_img_href};
    end
  end

  assign bus.post_img_vsync = vsync_sr[PIPE_LAT-1];
  assign bus.post_img_href  = href_sr[PIPE_LAT-1];
  assign bus.post_img_gray  = gray_q;

`ifdef RGB2GRAY_CBCR_EN
  logic signed [17:0] cb_r_prod, cb_g_prod, cb_b_prod, cb_sum;
  logic signed [17:0] cr_r_prod, cr_g_prod, cr_b_prod, cr_sum;
  pix8_t              cb_q, cr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cb_r_prod <= '0;
      cb_g_prod <= '0;
      cb_b_prod <= '0;
      cr_r_prod <= '0;
      cr_g_prod <= '0;
      cr_b_prod <= '0;
      cb_sum    <= '0;
      cr_sum    <= '0;
      cb_q      <= '0;
      cr_q      <= '0;
    end else begin
      cb_r_prod <= CB_R * to_s18(bus.per_img_red);
      cb_g_prod <= CB_G * to_s18(bus.per_img_green);
      cb_b_prod <= CB_B * to_s18(bus.per_img_blue);
      cr_r_prod <= CR_R * to_s18(bus.per_img_red);
      cr_g_prod <= CR_G * to_s18(bus.per_img_green);
      cr_b_prod <= CR_B * to_s18(bus.per_img_blue);
      cb_sum    <= cb_r_prod + cb_g_prod + cb_b_prod + C_OFS;
      cr_sum    <= cr_r_prod + cr_g_prod + cr_b_prod + C_OFS;
      cb_q      <= href_s2 ? clamp_u8(cb_sum) : '0;
      cr_q      <= href_s2 ? clamp_u8(cr_sum) : '0;
    end
  end

  assign bus.post_img_cb = cb_q;
  assign bus.post_img_cr = cr_q;
`endif

  rgb2gray_frame_mon #(
    .IMG_H_DISP(IMG_H_DISP),
    .IMG_V_DISP(IMG_V_DISP)
  ) u_frame_mon (
    .clk       (clk),
    .rst       (rst),
    .vsync     (bus.per_img_vsync),
    .href      (bus.per_img_href),
    .frame_done(bus.frame_done),
    .frame_err (bus.frame_err)
  );

endmodule

// File: tb/tb_rgb888_to_gray_proc.sv
// Directed bench for rgb888_to_gray_proc on a reduced 16x12 frame geometry.
// Chroma vectors run only when RGB2GRAY_CBCR_EN is defined.
module tb_rgb888_to_gray_proc;
  import img_proc_pkg::*;

  localparam int H   = 16;
  localparam int V   = 12;
  localparam int GAP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected output history: index 2 is what the outputs show now, index 3 the cycle before.
  logic  hv [0:3];
  logic  hh [0:3];
  pix8_t hg [0:3];

  rgb888_to_gray_proc_if bus ();

  rgb888_to_gray_proc #(
    .IMG_H_DISP(H),
    .IMG_V_DISP(V)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic pix8_t exp_gray(input pix8_t r, input pix8_t g, input pix8_t b);
    int s;
    s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b) + 128;
    return 8'(s >> 8);
  endfunction

  task automatic drive(input logic v, input logic h, input pix8_t r, input pix8_t g,
                       input pix8_t b, input logic rs);
    bus.per_img_vsync = v;
    bus.per_img_href  = h;
    bus.per_img_red   = r;
    bus.per_img_green = g;
    bus.per_img_blue  = b;
    rst               = rs;
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        hv[i] = 1'b0;
        hh[i] = 1'b0;
        hg[i] = '0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        hv[i] = hv[i-1];
        hh[i] = hh[i-1];
        hg[i] = hg[i-1];
      end
      hv[0] = v;
      hh[0] = h;
      hg[0] = h ? exp_gray(r, g, b) : 8'h00;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.post_img_vsync, bus.post_img_href, bus.post_img_gray, bus.frame_done, bus.frame_err} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs: got v=%b h=%b gray=%02h done=%b err=%b, required all 0",
                 bus.post_img_vsync, bus.post_img_href, bus.post_img_gray, bus.frame_done, bus.frame_err);
      end
      drive(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, c == 0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    end
  endtask

  task automatic test_colour_points();
    pix8_t cr [5] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    pix8_t cg [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    pix8_t cb [5] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    pix8_t cy [5] = '{8'hFF, 8'h4D, 8'h95, 8'h1D, 8'h00};
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, cr[p], cg[p], cb[p], 1'b0);
      repeat (2) begin
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      end
      @(negedge clk);
      n_checks++;
      if (bus.post_img_gray !== cy[p] || bus.post_img_href !== 1'b1 || bus.post_img_vsync !== 1'b0) begin
        n_fail++;
        $display("FAIL colour_point_%0d: got gray=%02h href=%b vsync=%b, required gray=%02h href=1 vsync=0",
                 p, bus.post_img_gray, bus.post_img_href, bus.post_img_vsync, cy[p]);
      end
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bus.post_img_gray !== 8'h00 || bus.post_img_href !== 1'b0 || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL colour_gate_%0d: got gray=%02h href=%b done=%b, required 00/0/0",
                 p, bus.post_img_gray, bus.post_img_href, bus.frame_done);
      end
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    end
  endtask

  // Four consecutive pixels with vsync low: converted and passed, never counted as a frame.
  task automatic test_back_to_back();
    pix8_t cr [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    pix8_t cg [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    pix8_t cb [4] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    pix8_t cy [4] = '{8'hFF, 8'h4D, 8'h95, 8'h1D};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 3 && c < 7) begin
        n_checks++;
        if (bus.post_img_gray !== cy[c-3] || bus.post_img_href !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back_%0d: got gray=%02h href=%b, required gray=%02h href=1",
                   c - 3, bus.post_img_gray, bus.post_img_href, cy[c-3]);
        end
      end
      n_checks++;
      if (bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL href_no_vsync_done: got frame_done=%b, required 0", bus.frame_done);
      end
      if (c < 4) drive(1'b0, 1'b1, cr[c], cg[c], cb[c], 1'b0);
      else       drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    end
  endtask

  task automatic run_frame(input string name, input int n_lines, input int lead,
                           input int short_line, input int reset_row,
                           input logic checked, input logic exp_err);
    int    total, j, line, col, len, n_done;
    logic  v, h, rs, exp_done;
    pix8_t r, g, b;
    total  = 3 + lead + n_lines * (H + GAP) + 10;
    n_done = 0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.post_img_vsync !== hv[2] || bus.post_img_href !== hh[2]) begin
        n_fail++;
        $display("FAIL %s_sync cyc %0d: got vsync=%b href=%b, required vsync=%b href=%b",
                 name, i, bus.post_img_vsync, bus.post_img_href, hv[2], hh[2]);
      end
      n_checks++;
      if (bus.post_img_gray !== hg[2]) begin
        n_fail++;
        $display("FAIL %s_gray cyc %0d: got %02h, required %02h", name, i, bus.post_img_gray, hg[2]);
      end
      exp_done = checked && hv[3] && !hv[2];
      n_checks++;
      if (bus.frame_done !== exp_done) begin
        n_fail++;
        $display("FAIL %s_done cyc %0d: got %b, required %b", name, i, bus.frame_done, exp_done);
      end
      if (exp_done) begin
        n_checks++;
        if (bus.frame_err !== exp_err) begin
          n_fail++;
          $display("FAIL %s_err: got %b, required %b", name, bus.frame_err, exp_err);
        end
      end
      if (bus.frame_done === 1'b1) n_done++;

      v = 1'b0; h = 1'b0; rs = 1'b0; r = '0; g = '0; b = '0;
      if (i >= 3 && i < 3 + lead) begin
        v = 1'b1;
      end else if (i >= 3 + lead && i < 3 + lead + n_lines * (H + GAP)) begin
        j    = i - 3 - lead;
        line = j / (H + GAP);
        col  = j % (H + GAP);
        len  = (line == short_line) ? H - 1 : H;
        v    = 1'b1;
        h    = (col < len);
        r    = 8'(col * 13 + line * 7);
        g    = 8'(line * 21 + 5);
        b    = 8'(255 - col * 9);
        if (line == reset_row && col < 2) begin
          rs = 1'b1;
          h  = 1'b0;
        end
      end
      drive(v, h, r, g, b, rs);
    end
    n_checks++;
    if (n_done != (checked ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d pulses, required %0d", name, n_done, checked ? 1 : 0);
    end
  endtask

  task automatic test_full_frame();
    run_frame("full_frame", V, 2, -1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_short_line();
    run_frame("short_line", V, 2, 5, -1, 1'b1, 1'b1);
  endtask

  task automatic test_missing_line();
    run_frame("missing_line", V - 1, 2, -1, -1, 1'b1, 1'b1);
  endtask

  task automatic test_zero_line_frame();
    run_frame("zero_line", 0, 1, -1, -1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame("reset_mid_frame", V, 2, -1, 7, 1'b0, 1'b0);
  endtask

  task automatic test_good_frame(input string name);
    run_frame(name, V, 2, -1, -1, 1'b1, 1'b0);
  endtask

`ifdef RGB2GRAY_CBCR_EN
  task automatic test_cbcr();
    pix8_t cr [3]  = '{8'd128, 8'hFF, 8'h00};
    pix8_t cg [3]  = '{8'd128, 8'h00, 8'h00};
    pix8_t cb [3]  = '{8'd128, 8'h00, 8'hFF};
    pix8_t ecb [3] = '{8'h80, 8'h55, 8'hFF};
    pix8_t ecr [3] = '{8'h80, 8'hFF, 8'h6B};
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, cr[p], cg[p], cb[p], 1'b0);
      repeat (2) begin
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      end
      @(negedge clk);
      n_checks++;
      if (bus.post_img_cb !== ecb[p] || bus.post_img_cr !== ecr[p]) begin
        n_fail++;
        $display("FAIL cbcr_%0d: got cb=%02h cr=%02h, required cb=%02h cr=%02h",
                 p, bus.post_img_cb, bus.post_img_cr, ecb[p], ecr[p]);
      end
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bus.post_img_cb !== 8'h00 || bus.post_img_cr !== 8'h00) begin
        n_fail++;
        $display("FAIL cbcr_gate_%0d: got cb=%02h cr=%02h, required 00/00",
                 p, bus.post_img_cb, bus.post_img_cr);
      end
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    end
  endtask
`endif

  initial begin
    bus.per_img_vsync = 1'b0;
    bus.per_img_href  = 1'b0;
    bus.per_img_red   = '0;
    bus.per_img_green = '0;
    bus.per_img_blue  = '0;
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      hh[i] = 1'b0;
      hg[i] = '0;
    end

    test_reset();
    test_colour_points();
    test_back_to_back();
    test_full_frame();
    test_short_line();
    test_good_frame("good_after_short");
    test_missing_line();
    test_good_frame("good_after_missing");
    test_zero_line_frame();
    test_reset_mid_frame();
    test_good_frame("good_after_reset");
`ifdef RGB2GRAY_CBCR_EN
    test_cbcr();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
